// File: rtl/ap_mem_pkg.sv
// Shared memory-port definitions: FSM state codes seen by the data cache and burst lengths.
package ap_mem_pkg;

  localparam int DEFAULT_CACHE_DEPTH = 16;

  // MEM_WRITE_DATA_STORE is decoded by the data cache to gate its store counter.
  typedef enum logic [3:0] {
    IDLE                 = 4'd0,
    RD_DATA              = 4'd2,
    RD_JMP               = 4'd4,
    MEM_WRITE_DATA_STORE = 4'd9,
    WAIT_RELEASE         = 4'd10
  } mem_state_t;

  typedef enum logic [1:0] {
    SVC_NONE  = 2'd0,
    SVC_LOAD  = 2'd1,
    SVC_JMP   = 2'd2,
    SVC_STORE = 2'd3
  } svc_t;

  function automatic logic [9:0] data_burst_len(input int depth);
    return 10'(depth + 1);
  endfunction

  function automatic logic [9:0] store_burst_len(input int depth);
    return 10'(depth);
  endfunction

  localparam logic [9:0] JMP_BURST_LEN   = 10'd1;
  localparam logic [9:0] DATA_BURST_LEN  = data_burst_len(DEFAULT_CACHE_DEPTH);
  localparam logic [9:0] STORE_BURST_LEN = store_burst_len(DEFAULT_CACHE_DEPTH);

endpackage

// File: rtl/ddr_rd_beat_pipe.sv
// Registered read-beat stage: forwards controller beats to the cache one cycle later with a
// 1-based, length-saturated beat count, and captures the jump address from beat 1.
module ddr_rd_beat_pipe
  import ap_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      active,
  input  logic                      jmp_mode,
  input  logic [9:0]                len,
  input  logic                      beat_valid,
  input  logic [DDR_DATA_WIDTH-1:0] beat_data,
  output logic                      data_valid,
  output logic [9:0]                cnt,
  output logic [DATA_WIDTH-1:0]     data,
  output logic [DDR_ADDR_WIDTH-1:0] jmp_addr
);

  logic accept_s;
  logic unused_bits_s;

  // Beats past the burst length are silently dropped
  always_comb begin
    accept_s      = active && beat_valid && (cnt < len);
    unused_bits_s = ^beat_data;
  end

  // Beat register, counter and jump-address capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid <= 1'b0;
      cnt        <= 10'd0;
      data       <= '0;
      jmp_addr   <= '0;
    end else begin
      data_valid <= accept_s;
      if (clr) begin
        cnt <= 10'd0;
      end else if (accept_s) begin
        cnt  <= cnt + 10'd1;
        data <= beat_data[DATA_WIDTH-1:0];
        if (jmp_mode && (cnt == 10'd0)) begin
          jmp_addr <= beat_data[DDR_ADDR_WIDTH-1:0];
        end else begin
          jmp_addr <= jmp_addr;
        end
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule

// File: rtl/ddr_data_port.sv
// Data-cache to DDR controller bridge: turns level-held load/jump/store requests into single
// bursts, returns read beats with a beat index and mirrors write-beat requests to the cache.
module ddr_data_port
  import ap_mem_pkg::*;
#(
  parameter int DATA_CACHE_DEPTH = DEFAULT_CACHE_DEPTH,
  parameter int DATA_WIDTH       = 16,
  parameter int DDR_ADDR_WIDTH   = 28,
  parameter int DDR_DATA_WIDTH   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DATA_read_req,
  input  logic                      JMP_ADDR_read_req,
  input  logic                      DATA_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
  output logic                      rd_burst_data_valid,
  output logic [9:0]                rd_cnt_data,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,
  output logic                      ddr_rd_req,
  output logic [9:0]                ddr_rd_len,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      ddr_rd_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                      ddr_rd_finish,
  output logic                      ddr_wr_req,
  output logic [9:0]                ddr_wr_len,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
  input  logic                      ddr_wr_data_req,
  output logic [DDR_DATA_WIDTH-1:0] ddr_wr_data,
  input  logic                      ddr_wr_finish
);

  mem_state_t state_r;
  svc_t       svc_r;
  logic       burst_start_s;
  logic       rd_active_s;
  logic       jmp_mode_s;
  logic       svc_req_s;

  // Decode FSM state and track the request that opened the current burst
  always_comb begin
    burst_start_s = (state_r == IDLE) && (DATA_store_req || JMP_ADDR_read_req || DATA_read_req);
    rd_active_s   = (state_r == RD_DATA) || (state_r == RD_JMP);
    jmp_mode_s    = (state_r == RD_JMP);
    case (svc_r)
      SVC_LOAD:  svc_req_s = DATA_read_req;
      SVC_JMP:   svc_req_s = JMP_ADDR_read_req;
      SVC_STORE: svc_req_s = DATA_store_req;
      default:   svc_req_s = 1'b0;
    endcase
  end

  // Burst FSM with registered controller request, address and length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      svc_r       <= SVC_NONE;
      ddr_rd_req  <= 1'b0;
      ddr_rd_len  <= 10'd0;
      ddr_rd_addr <= '0;
      ddr_wr_req  <= 1'b0;
      ddr_wr_len  <= 10'd0;
      ddr_wr_addr <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (DATA_store_req) begin
            state_r     <= MEM_WRITE_DATA_STORE;
            svc_r       <= SVC_STORE;
            ddr_wr_req  <= 1'b1;
            ddr_wr_len  <= store_burst_len(DATA_CACHE_DEPTH);
            ddr_wr_addr <= DATA_write_addr;
          end else if (JMP_ADDR_read_req) begin
            state_r     <= RD_JMP;
            svc_r       <= SVC_JMP;
            ddr_rd_req  <= 1'b1;
            ddr_rd_len  <= JMP_BURST_LEN;
            ddr_rd_addr <= DATA_read_addr;
          end else if (DATA_read_req) begin
            state_r     <= RD_DATA;
            svc_r       <= SVC_LOAD;
            ddr_rd_req  <= 1'b1;
            ddr_rd_len  <= data_burst_len(DATA_CACHE_DEPTH);
            ddr_rd_addr <= DATA_read_addr;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_DATA, RD_JMP: begin
          if (ddr_rd_finish) begin
            ddr_rd_req <= 1'b0;
            state_r    <= WAIT_RELEASE;
          end else begin
            state_r <= state_r;
          end
        end
        MEM_WRITE_DATA_STORE: begin
          if (ddr_wr_finish) begin
            ddr_wr_req <= 1'b0;
            state_r    <= WAIT_RELEASE;
          end else begin
            state_r <= state_r;
          end
        end
        // Hold off until the cache drops the serviced request so it is not re-issued
        WAIT_RELEASE: begin
          if (!svc_req_s) begin
            state_r <= IDLE;
            svc_r   <= SVC_NONE;
          end else begin
            state_r <= WAIT_RELEASE;
          end
        end
        default: begin
          state_r    <= IDLE;
          svc_r      <= SVC_NONE;
          ddr_rd_req <= 1'b0;
          ddr_wr_req <= 1'b0;
        end
      endcase
    end
  end

  // Write beats pass straight through; the cache answers a request one cycle later
  always_comb begin
    if (state_r == MEM_WRITE_DATA_STORE) begin
      wr_burst_data_req = ddr_wr_data_req;
      ddr_wr_data       = DDR_DATA_WIDTH'(DATA_to_ddr);
    end else begin
      wr_burst_data_req = 1'b0;
      ddr_wr_data       = '0;
    end
  end

  assign state_interface_module = state_r;

  ddr_rd_beat_pipe #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DDR_ADDR_WIDTH (DDR_ADDR_WIDTH),
    .DDR_DATA_WIDTH (DDR_DATA_WIDTH)
  ) u_rd_beat_pipe (
    .clk        (clk),
    .rst        (rst),
    .clr        (burst_start_s),
    .active     (rd_active_s),
    .jmp_mode   (jmp_mode_s),
    .len        (ddr_rd_len),
    .beat_valid (ddr_rd_data_valid),
    .beat_data  (ddr_rd_data),
    .data_valid (rd_burst_data_valid),
    .cnt        (rd_cnt_data),
    .data       (DATA_to_cache),
    .jmp_addr   (JMP_ADDR_to_cache)
  );

endmodule

// File: tb/tb_ddr_data_port.sv
// Self-checking bench for ddr_data_port: plays the data cache and the DDR controller with
// randomized beats and gaps, and checks outputs against expectations derived from the burst rules.
module tb_ddr_data_port;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int AW    = 28;
  localparam int DDW   = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           DATA_read_req = 1'b0, JMP_ADDR_read_req = 1'b0, DATA_store_req = 1'b0;
  logic [AW-1:0]  DATA_read_addr = '0, DATA_write_addr = '0;
  logic [DW-1:0]  DATA_to_ddr = '0;
  logic [DW-1:0]  DATA_to_cache;
  logic [AW-1:0]  JMP_ADDR_to_cache;
  logic           rd_burst_data_valid;
  logic [9:0]     rd_cnt_data;
  logic           wr_burst_data_req;
  logic [3:0]     state_interface_module;
  logic           ddr_rd_req;
  logic [9:0]     ddr_rd_len;
  logic [AW-1:0]  ddr_rd_addr;
  logic           ddr_rd_data_valid = 1'b0;
  logic [DDW-1:0] ddr_rd_data = '0;
  logic           ddr_rd_finish = 1'b0;
  logic           ddr_wr_req;
  logic [9:0]     ddr_wr_len;
  logic [AW-1:0]  ddr_wr_addr;
  logic           ddr_wr_data_req = 1'b0;
  logic [DDW-1:0] ddr_wr_data;
  logic           ddr_wr_finish = 1'b0;

  int checks = 0;
  int errors = 0;
  logic overlap = 1'b0;

  wire [201:0] all_outs = {DATA_to_cache, JMP_ADDR_to_cache, rd_burst_data_valid, rd_cnt_data,
                           wr_burst_data_req, state_interface_module, ddr_rd_req, ddr_rd_len,
                           ddr_rd_addr, ddr_wr_req, ddr_wr_len, ddr_wr_addr, ddr_wr_data};

  ddr_data_port #(
    .DATA_CACHE_DEPTH (DEPTH), .DATA_WIDTH (DW), .DDR_ADDR_WIDTH (AW), .DDR_DATA_WIDTH (DDW)
  ) dut (
    .clk (clk), .rst (rst),
    .DATA_read_req (DATA_read_req), .JMP_ADDR_read_req (JMP_ADDR_read_req),
    .DATA_store_req (DATA_store_req), .DATA_read_addr (DATA_read_addr),
    .DATA_write_addr (DATA_write_addr), .DATA_to_ddr (DATA_to_ddr),
    .DATA_to_cache (DATA_to_cache), .JMP_ADDR_to_cache (JMP_ADDR_to_cache),
    .rd_burst_data_valid (rd_burst_data_valid), .rd_cnt_data (rd_cnt_data),
    .wr_burst_data_req (wr_burst_data_req), .state_interface_module (state_interface_module),
    .ddr_rd_req (ddr_rd_req), .ddr_rd_len (ddr_rd_len), .ddr_rd_addr (ddr_rd_addr),
    .ddr_rd_data_valid (ddr_rd_data_valid), .ddr_rd_data (ddr_rd_data),
    .ddr_rd_finish (ddr_rd_finish), .ddr_wr_req (ddr_wr_req), .ddr_wr_len (ddr_wr_len),
    .ddr_wr_addr (ddr_wr_addr), .ddr_wr_data_req (ddr_wr_data_req),
    .ddr_wr_data (ddr_wr_data), .ddr_wr_finish (ddr_wr_finish)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ddr_rd_req && ddr_wr_req) overlap = 1'b1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (all_outs !== 202'd0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    rst = 1'b1;
    step();
    checks++;
    if (state_interface_module !== 4'd0) begin
      errors++; $display("FAIL reset_idle: got %0d expected 0", state_interface_module);
    end
  endtask

  task automatic test_load(input int n);
    logic [AW-1:0]  addr;
    logic [DDW-1:0] beat;
    int exp_cnt;
    for (int it = 0; it < n; it++) begin
      addr = (it == 0) ? 28'h0000800 : AW'($urandom);
      DATA_read_req = 1'b1; DATA_read_addr = addr;
      step();
      DATA_read_addr = AW'($urandom);
      checks++;
      if (state_interface_module !== 4'd2 || ddr_rd_req !== 1'b1 || ddr_rd_addr !== addr ||
          ddr_rd_len !== 10'(DEPTH + 1) || ddr_wr_req !== 1'b0 || rd_cnt_data !== 10'd0) begin
        errors++;
        $display("FAIL load_issue: state %0d req %b addr %h len %0d cnt %0d expected 2 1 %h %0d 0",
                 state_interface_module, ddr_rd_req, ddr_rd_addr, ddr_rd_len, rd_cnt_data, addr, DEPTH + 1);
      end
      exp_cnt = 0;
      for (int b = 0; b < DEPTH + 1; b++) begin
        repeat ($urandom_range(0, 2)) begin
          ddr_rd_data_valid = 1'b0;
          step();
          checks++;
          if (rd_burst_data_valid !== 1'b0 || rd_cnt_data !== 10'(exp_cnt)) begin
            errors++;
            $display("FAIL load_gap: valid %b cnt %0d expected 0 %0d", rd_burst_data_valid, rd_cnt_data, exp_cnt);
          end
        end
        beat = {$urandom, $urandom};
        beat[15:0] = 16'hA000 + 16'(b);
        ddr_rd_data = beat; ddr_rd_data_valid = 1'b1;
        if (it == 1 && b == 8) DATA_read_req = 1'b0;
        step();
        exp_cnt++;
        checks++;
        if (rd_burst_data_valid !== 1'b1 || rd_cnt_data !== 10'(exp_cnt) ||
            DATA_to_cache !== beat[15:0] || ddr_rd_req !== 1'b1 || ddr_rd_addr !== addr) begin
          errors++;
          $display("FAIL load_beat: valid %b cnt %0d data %h req %b expected 1 %0d %h 1",
                   rd_burst_data_valid, rd_cnt_data, DATA_to_cache, ddr_rd_req, exp_cnt, beat[15:0]);
        end
      end
      ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b1;
      step();
      ddr_rd_finish = 1'b0;
      checks++;
      if (state_interface_module !== 4'd10 || ddr_rd_req !== 1'b0 || rd_cnt_data !== 10'(DEPTH + 1)) begin
        errors++;
        $display("FAIL load_finish: state %0d req %b cnt %0d expected 10 0 %0d",
                 state_interface_module, ddr_rd_req, rd_cnt_data, DEPTH + 1);
      end
      if (it == 0) begin
        repeat (3) begin
          step();
          checks++;
          if (state_interface_module !== 4'd10 || ddr_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL held_request: state %0d req %b expected 10 0", state_interface_module, ddr_rd_req);
          end
        end
      end
      DATA_read_req = 1'b0;
      step();
      checks++;
      if (state_interface_module !== 4'd0) begin
        errors++; $display("FAIL load_release: state %0d expected 0", state_interface_module);
      end
    end
  endtask

  task automatic test_jump();
    logic [AW-1:0] addr;
    addr = AW'($urandom);
    JMP_ADDR_read_req = 1'b1; DATA_read_addr = addr;
    step();
    checks++;
    if (state_interface_module !== 4'd4 || ddr_rd_len !== 10'd1 || ddr_rd_addr !== addr || ddr_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL jump_issue: state %0d len %0d addr %h expected 4 1 %h", state_interface_module, ddr_rd_len, ddr_rd_addr, addr);
    end
    ddr_wr_finish = 1'b1;
    step();
    ddr_wr_finish = 1'b0;
    checks++;
    if (state_interface_module !== 4'd4 || ddr_rd_req !== 1'b1) begin
      errors++; $display("FAIL wrong_finish: state %0d req %b expected 4 1", state_interface_module, ddr_rd_req);
    end
    ddr_rd_data = 64'h0000_0000_0123_4567; ddr_rd_data_valid = 1'b1;
    step();
    checks++;
    if (JMP_ADDR_to_cache !== 28'h1234567 || rd_cnt_data !== 10'd1 || rd_burst_data_valid !== 1'b1 ||
        DATA_to_cache !== 16'h4567) begin
      errors++;
      $display("FAIL jump_beat: jmp %h cnt %0d valid %b data %h expected 1234567 1 1 4567",
               JMP_ADDR_to_cache, rd_cnt_data, rd_burst_data_valid, DATA_to_cache);
    end
    ddr_rd_data = {$urandom, $urandom};
    step();
    ddr_rd_data_valid = 1'b0;
    checks++;
    if (rd_burst_data_valid !== 1'b0 || rd_cnt_data !== 10'd1 || JMP_ADDR_to_cache !== 28'h1234567 ||
        DATA_to_cache !== 16'h4567) begin
      errors++;
      $display("FAIL overrun_beat: valid %b cnt %0d jmp %h data %h expected 0 1 1234567 4567",
               rd_burst_data_valid, rd_cnt_data, JMP_ADDR_to_cache, DATA_to_cache);
    end
    ddr_rd_finish = 1'b1;
    step();
    ddr_rd_finish = 1'b0;
    JMP_ADDR_read_req = 1'b0;
    step();
    checks++;
    if (state_interface_module !== 4'd0 || JMP_ADDR_to_cache !== 28'h1234567) begin
      errors++;
      $display("FAIL jump_release: state %0d jmp %h expected 0 1234567", state_interface_module, JMP_ADDR_to_cache);
    end
  endtask

  task automatic test_store();
    logic [DW-1:0] word;
    DATA_store_req = 1'b1; DATA_write_addr = 28'h0028000;
    step();
    checks++;
    if (state_interface_module !== 4'd9 || ddr_wr_req !== 1'b1 || ddr_wr_len !== 10'(DEPTH) ||
        ddr_wr_addr !== 28'h0028000 || ddr_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL store_issue: state %0d req %b len %0d addr %h expected 9 1 %0d 0028000",
               state_interface_module, ddr_wr_req, ddr_wr_len, ddr_wr_addr, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      repeat ($urandom_range(0, 1)) begin
        ddr_wr_data_req = 1'b0;
        step();
        checks++;
        if (wr_burst_data_req !== 1'b0) begin
          errors++; $display("FAIL store_idle_req: got %b expected 0", wr_burst_data_req);
        end
      end
      ddr_wr_data_req = 1'b1;
      #1;
      checks++;
      if (wr_burst_data_req !== 1'b1) begin
        errors++; $display("FAIL store_req_mirror: got %b expected 1", wr_burst_data_req);
      end
      step();
      ddr_wr_data_req = 1'b0;
      word = DW'($urandom);
      DATA_to_ddr = word;
      #1;
      checks++;
      if (ddr_wr_data !== {48'd0, word}) begin
        errors++; $display("FAIL store_data: got %h expected %h", ddr_wr_data, {48'd0, word});
      end
    end
    ddr_wr_finish = 1'b1;
    step();
    ddr_wr_finish = 1'b0;
    checks++;
    if (state_interface_module !== 4'd10 || ddr_wr_req !== 1'b0) begin
      errors++; $display("FAIL store_finish: state %0d req %b expected 10 0", state_interface_module, ddr_wr_req);
    end
    DATA_store_req = 1'b0;
    step();
    checks++;
    if (state_interface_module !== 4'd0) begin
      errors++; $display("FAIL store_release: state %0d expected 0", state_interface_module);
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'd9; exp_seq[1] = 4'd4; exp_seq[2] = 4'd2;
    overlap = 1'b0;
    DATA_store_req = 1'b1; JMP_ADDR_read_req = 1'b1; DATA_read_req = 1'b1;
    DATA_read_addr = AW'($urandom); DATA_write_addr = AW'($urandom);
    step();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (state_interface_module !== exp_seq[s]) begin
        errors++; $display("FAIL priority_order: state %0d expected %0d", state_interface_module, exp_seq[s]);
      end
      if (s == 0) ddr_wr_finish = 1'b1; else ddr_rd_finish = 1'b1;
      step();
      ddr_wr_finish = 1'b0; ddr_rd_finish = 1'b0;
      if (s == 0) DATA_store_req = 1'b0;
      else if (s == 1) JMP_ADDR_read_req = 1'b0;
      else DATA_read_req = 1'b0;
      step();
      checks++;
      if (state_interface_module !== 4'd0) begin
        errors++; $display("FAIL priority_release: state %0d expected 0", state_interface_module);
      end
      if (s < 2) step();
    end
    checks++;
    if (overlap !== 1'b0) begin
      errors++; $display("FAIL priority_overlap: got %b expected 0", overlap);
    end
  endtask

  task automatic test_reset_mid_burst();
    DATA_read_req = 1'b1; DATA_read_addr = AW'($urandom);
    step();
    for (int b = 0; b < 4; b++) begin
      ddr_rd_data = {$urandom, $urandom}; ddr_rd_data_valid = 1'b1;
      step();
    end
    checks++;
    if (rd_cnt_data !== 10'd4) begin
      errors++; $display("FAIL pre_reset_cnt: got %0d expected 4", rd_cnt_data);
    end
    ddr_rd_data = {$urandom, $urandom};
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs !== 202'd0) begin
      errors++; $display("FAIL reset_mid_burst: got %h expected 0", all_outs);
    end
    ddr_rd_data_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (state_interface_module !== 4'd2 || ddr_rd_req !== 1'b1 || rd_cnt_data !== 10'd0) begin
      errors++;
      $display("FAIL reissue: state %0d req %b cnt %0d expected 2 1 0", state_interface_module, ddr_rd_req, rd_cnt_data);
    end
    ddr_rd_data = 64'h0000_0000_0000_BEEF; ddr_rd_data_valid = 1'b1;
    step();
    ddr_rd_data_valid = 1'b0;
    checks++;
    if (rd_cnt_data !== 10'd1 || DATA_to_cache !== 16'hBEEF) begin
      errors++; $display("FAIL restart_cnt: cnt %0d data %h expected 1 beef", rd_cnt_data, DATA_to_cache);
    end
    ddr_rd_finish = 1'b1; DATA_read_req = 1'b0;
    step();
    ddr_rd_finish = 1'b0;
    step();
    checks++;
    if (state_interface_module !== 4'd0) begin
      errors++; $display("FAIL restart_release: state %0d expected 0", state_interface_module);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load(4);
    test_jump();
    test_store();
    test_priority();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_data_port.md
Name: ddr_data_port

Overview:
- Downstream neighbour of the data cache: converts the cache's level-held DATA_read_req, JMP_ADDR_read_req and DATA_store_req into single bursts on the DDR controller's user read/write burst interface.
- Returns read beats to the cache with a 1-based beat counter.
- Paces write beats using the cache's one-cycle write-data latency.
- Publishes its FSM state as state_interface_module. The cache uses this to gate its store counter.

Parameters:
- DATA_CACHE_DEPTH, 16, cache lines per burst.
- DATA_WIDTH, 16, cache word width.
- DDR_ADDR_WIDTH, 28, DDR address width.
- DDR_DATA_WIDTH, 64, controller data width; must be ≥ DDR_ADDR_WIDTH and ≥ DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- DATA_read_req  in  1  cache data-load request, level
- JMP_ADDR_read_req  in  1  cache jump-address request, level
- DATA_store_req  in  1  cache store request, level
- DATA_read_addr  in  DDR_ADDR_WIDTH  read address (load and jump)
- DATA_write_addr  in  DDR_ADDR_WIDTH  write address
- DATA_to_ddr  in  DATA_WIDTH  write word from cache, valid one cycle after wr_burst_data_req
- DATA_to_cache  out  DATA_WIDTH  read word to cache
- JMP_ADDR_to_cache  out  DDR_ADDR_WIDTH  jump address to cache
- rd_burst_data_valid  out  1  read beat valid to cache
- rd_cnt_data  out  10  1-based beat index of the current read beat
- wr_burst_data_req  out  1  write-beat request to cache
- state_interface_module  out  4  current FSM state code
- ddr_rd_req  out  1  controller read burst request
- ddr_rd_len  out  10  read burst length in beats
- ddr_rd_addr  out  DDR_ADDR_WIDTH  read burst address
- ddr_rd_data_valid  in  1  controller read beat valid
- ddr_rd_data  in  DDR_DATA_WIDTH  controller read beat
- ddr_rd_finish  in  1  read burst done pulse
- ddr_wr_req  out  1  controller write burst request
- ddr_wr_len  out  10  write burst length in beats
- ddr_wr_addr  out  DDR_ADDR_WIDTH  write burst address
- ddr_wr_data_req  in  1  controller write-beat request
- ddr_wr_data  out  DDR_DATA_WIDTH  write beat, zero-extended DATA_to_ddr
- ddr_wr_finish  in  1  write burst done pulse

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk. All state and registered outputs rise on clk.
- Reset values: all outputs 0; state_interface_module = IDLE (4'd0).
- Reset mid-burst abandons the burst. The controller shares rst and also aborts.
- State codes:
  - IDLE 0
  - RD_DATA 2
  - RD_JMP 4
  - MEM_WRITE_DATA_STORE 9 (fixed; the cache decodes it)
  - WAIT_RELEASE 10
- IDLE arbitration, sampled each cycle, fixed priority DATA_store_req > JMP_ADDR_read_req > DATA_read_req:
  - store → MEM_WRITE_DATA_STORE. Latch ddr_wr_addr = DATA_write_addr, ddr_wr_len = DATA_CACHE_DEPTH, ddr_wr_req = 1.
  - jmp → RD_JMP. Latch ddr_rd_addr = DATA_read_addr, ddr_rd_len = 1, ddr_rd_req = 1.
  - load → RD_DATA. Latch ddr_rd_addr = DATA_read_addr, ddr_rd_len = DATA_CACHE_DEPTH+1, ddr_rd_req = 1. Beat 1 is discarded by the cache; beats 2..DEPTH+1 fill lines 0..DEPTH-1.
- Burst request handshake: ddr_rd_req/ddr_wr_req, address and length are held stable until the matching finish pulse.
- Read path (RD_DATA/RD_JMP), registered, 1-cycle latency:
  - beat counter clears to 0 on IDLE exit and increments on each ddr_rd_data_valid.
  - Cycle after a controller beat: rd_burst_data_valid = 1, rd_cnt_data = beat count including that beat (1..len), DATA_to_cache = ddr_rd_data[DATA_WIDTH-1:0].
  - In RD_JMP, JMP_ADDR_to_cache latches ddr_rd_data[DDR_ADDR_WIDTH-1:0] on beat 1 and holds until the next jump read.
  - rd_cnt_data holds its last value after the burst; it clears on the next burst start.
- Write path (MEM_WRITE_DATA_STORE), combinational:
  - wr_burst_data_req = ddr_wr_data_req.
  - ddr_wr_data = zero-extended DATA_to_ddr. The controller samples it the cycle after its request.
  - The block does not count write beats; the cache does.
- Completion:
  - ddr_rd_finish or ddr_wr_finish → deassert the request, go to WAIT_RELEASE.
  - WAIT_RELEASE → IDLE once the serviced request input is 0. This prevents re-issue while the cache leaves its state.
  - A finish pulse in the wrong state is ignored.
- Beyond-length reads: extra ddr_rd_data_valid beats beyond len are dropped, and rd_cnt_data saturates at len. Lost beats are not detected.
- Request changes during a burst: a request that drops mid-burst does not abort the burst. New requests wait in IDLE.

Decomposition:
- Shared package ap_mem_pkg holds:
  - state codes, with MEM_WRITE_DATA_STORE = 4'd9 shared with the data cache;
  - the burst length constants DATA_BURST_LEN = DATA_CACHE_DEPTH+1, JMP_BURST_LEN = 1, STORE_BURST_LEN = DATA_CACHE_DEPTH.
- One sub-module, ddr_rd_beat_pipe: the 1-cycle registered read beat/counter stage with saturation.

Test Plan:
- Load: DATA_read_req=1, addr 0x800 → ddr_rd_addr 0x800, len 17. Controller returns beats 0xA000..0xA010 → rd_cnt_data 1..17 with DATA_to_cache matching, each 1 cycle after its beat. After finish and req drop, state returns to 0.
- Jump: JMP_ADDR_read_req=1, beat 0x0000_0000_0123_4567 → JMP_ADDR_to_cache = 0x1234567, rd_cnt_data = 1, ddr_rd_len = 1.
- Store: DATA_store_req=1, addr 0x28000 → state 9, ddr_wr_len 16. Each ddr_wr_data_req is mirrored on wr_burst_data_req. ddr_wr_data = {48'b0, DATA_to_ddr} on the following cycle, 16 beats.
- Priority: all three requests asserted in the same cycle → write burst first, then jump, then load. No overlap between ddr_rd_req and ddr_wr_req.
- Held request: keep DATA_read_req=1 for 3 cycles after ddr_rd_finish → state stays 10, no second ddr_rd_req. Drop req → IDLE the next cycle.
- Reset mid-burst: rst=0 at beat 5 → all outputs 0 immediately. After release, a new load issues cleanly with the counter restarting at 1.
